// File: rtl/tpx3_rx_mux_pkg.sv
// Shared constants, register map and output-word packing for the Timepix3 multi-link merge stage.
package tpx3_rx_mux_pkg;

  localparam int VERSION   = 2;
  localparam int PAYLOAD_W = 25;
  localparam int OUT_W     = 32;

  localparam int REG_RST     = 0;
  localparam int REG_MASK_LO = 1;
  localparam int REG_MASK_HI = 2;
  localparam int REG_CTRL    = 3;
  localparam int REG_CNT_SEL = 4;
  localparam int REG_CNT0    = 5;
  localparam int REG_CNT1    = 6;
  localparam int REG_CNT2    = 7;
  localparam int REG_CNT3    = 8;
  localparam int REG_ERR_LO  = 9;
  localparam int REG_ERR_HI  = 10;

  // The identifier is shifted up by ch_w, so only its low 7-ch_w bits survive in the header.
  function automatic logic [OUT_W-1:0] pack_word(input logic [6:0] ident, input logic [3:0] ch,
                                                 input int ch_w, input logic [PAYLOAD_W-1:0] payload);
    logic [6:0] hdr;
    hdr = (ident << ch_w) | {3'b000, ch};
    return {hdr, payload};
  endfunction

endpackage

// File: rtl/tpx3_rx_mux_rr_arbiter.sv
// Combinational round-robin picker: first request at or above the pointer, wrapping around.
module tpx3_rx_rr_arbiter #(
  parameter int NUM_CH = 4,
  localparam int CH_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_ptr,
  output logic [NUM_CH-1:0] o_grant,
  output logic [CH_W-1:0]   o_idx,
  output logic              o_valid
);

  logic [CH_W-1:0] w_cand;

  // Scanning from the farthest offset down lets the closest requester overwrite the result.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_cand = i_ptr + CH_W'(k);
      if (i_req[w_cand]) begin
        o_grant         = '0;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
        o_valid         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tpx3_rx_mux.sv
// N-link merge into one tagged 32-bit FWFT stream with a byte-wide register bus.
// Define TPX3_RX_MUX_WORD_CNT_EN to build the per-channel word counters (regs 4..8).
module tpx3_rx_mux
  import tpx3_rx_mux_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int DATA_IDENTIFIER = 0,
  parameter int ABUSWIDTH       = 32,
  localparam int CH_W           = $clog2(NUM_CH)
) (
  input  logic                        BUS_CLK,
  input  logic                        RST,
  input  logic [NUM_CH-1:0]           CH_EMPTY,
  input  logic [NUM_CH*PAYLOAD_W-1:0] CH_DATA,
  output logic [NUM_CH-1:0]           CH_READ,
  input  logic [NUM_CH-1:0]           CH_READY,
  input  logic [NUM_CH-1:0]           CH_DEC_ERR,
  input  logic                        FIFO_READ,
  output logic                        FIFO_EMPTY,
  output logic [OUT_W-1:0]            FIFO_DATA,
  output logic                        RX_READY_ALL,
  input  logic [ABUSWIDTH-1:0]        BUS_ADD,
  input  logic [7:0]                  BUS_DATA_IN,
  output logic [7:0]                  BUS_DATA_OUT,
  input  logic                        BUS_WR,
  input  logic                        BUS_RD
);

  logic                 w_rst, w_valid, w_push, w_pop;
  logic [NUM_CH-1:0]    w_req, w_grant, w_grant_q;
  logic [CH_W-1:0]      w_idx;
  logic [OUT_W-1:0]     w_word;
  logic [PAYLOAD_W-1:0] w_ch_data [NUM_CH];
  logic [15:0]          w_mask16, w_err16, w_err_clr16;
  logic [7:0]           w_rd_data, w_sel8;
  logic [31:0]          w_cnt_live, w_snap;

  logic [NUM_CH-1:0]    r_mask, r_err;
  logic                 r_discard;
  logic [CH_W-1:0]      r_rr;
  logic [OUT_W-1:0]     r_buf [2];
  logic                 r_wr_ptr, r_rd_ptr;
  logic [1:0]           r_count;
  logic [7:0]           r_bus_data;

  assign w_rst = RST | (BUS_WR && BUS_ADD == ABUSWIDTH'(REG_RST));

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign w_ch_data[gi] = CH_DATA[gi*PAYLOAD_W +: PAYLOAD_W];
  end

  assign w_req = ~CH_EMPTY & r_mask;

  tpx3_rx_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .i_req   (w_req),
    .i_ptr   (r_rr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  assign w_push    = w_valid && !w_rst && ((r_count != 2'd2) || FIFO_READ);
  assign w_pop     = FIFO_READ && (r_count != 2'd0);
  assign w_grant_q = w_push ? w_grant : '0;
  assign w_word    = pack_word(7'(DATA_IDENTIFIER), 4'(w_idx), CH_W, w_ch_data[w_idx]);

  // Discard pops ignore the buffer state entirely; only the grant is throttled.
  assign CH_READ = w_rst ? '0 : (w_grant_q | (r_discard ? (~r_mask & ~CH_EMPTY) : '0));

  assign FIFO_EMPTY   = (r_count == 2'd0);
  assign FIFO_DATA    = r_buf[r_rd_ptr];
  assign RX_READY_ALL = &(CH_READY | ~r_mask);

  always_ff @(posedge BUS_CLK) begin
    if (w_rst) begin
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_rr     <= '0;
    end else begin
      if (w_push) begin
        r_buf[r_wr_ptr] <= w_word;
        r_wr_ptr        <= ~r_wr_ptr;
        r_rr            <= w_idx + 1'b1;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_mask16 = 16'(r_mask);
  assign w_err16  = 16'(r_err);

  always_comb begin
    w_err_clr16 = '0;
    if (BUS_WR && BUS_ADD == ABUSWIDTH'(REG_ERR_LO)) w_err_clr16[7:0]  = BUS_DATA_IN;
    if (BUS_WR && BUS_ADD == ABUSWIDTH'(REG_ERR_HI)) w_err_clr16[15:8] = BUS_DATA_IN;
  end

  // A decoder error arriving in the same cycle as its clear keeps the flag set.
  always_ff @(posedge BUS_CLK) begin
    if (w_rst) begin
      r_mask    <= '0;
      r_discard <= 1'b0;
      r_err     <= '0;
    end else begin
      r_err <= (r_err & ~NUM_CH'(w_err_clr16)) | CH_DEC_ERR;
      if (BUS_WR && BUS_ADD == ABUSWIDTH'(REG_MASK_LO)) r_mask <= NUM_CH'({w_mask16[15:8], BUS_DATA_IN});
      if (BUS_WR && BUS_ADD == ABUSWIDTH'(REG_MASK_HI)) r_mask <= NUM_CH'({BUS_DATA_IN, w_mask16[7:0]});
      if (BUS_WR && BUS_ADD == ABUSWIDTH'(REG_CTRL))    r_discard <= BUS_DATA_IN[1];
    end
  end

`ifdef TPX3_RX_MUX_WORD_CNT_EN
  logic [CH_W-1:0] r_cnt_sel;
  logic [31:0]     r_word_cnt [NUM_CH];
  logic [31:0]     r_snap;

  always_ff @(posedge BUS_CLK) begin
    if (w_rst) begin
      for (int k = 0; k < NUM_CH; k++) r_word_cnt[k] <= '0;
      r_cnt_sel <= '0;
      r_snap    <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++)
        if (w_grant_q[k] && r_word_cnt[k] != 32'hFFFF_FFFF) r_word_cnt[k] <= r_word_cnt[k] + 32'd1;
      if (BUS_WR && BUS_ADD == ABUSWIDTH'(REG_CNT_SEL)) r_cnt_sel <= BUS_DATA_IN[CH_W-1:0];
      if (BUS_RD && BUS_ADD == ABUSWIDTH'(REG_CNT0))    r_snap <= r_word_cnt[r_cnt_sel];
    end
  end

  assign w_sel8     = 8'(r_cnt_sel);
  assign w_cnt_live = r_word_cnt[r_cnt_sel];
  assign w_snap     = r_snap;
`else
  assign w_sel8     = 8'h00;
  assign w_cnt_live = 32'h0;
  assign w_snap     = 32'h0;
`endif

  always_comb begin
    w_rd_data = 8'h00;
    case (BUS_ADD)
      ABUSWIDTH'(REG_RST):     w_rd_data = 8'(VERSION);
      ABUSWIDTH'(REG_MASK_LO): w_rd_data = w_mask16[7:0];
      ABUSWIDTH'(REG_MASK_HI): w_rd_data = w_mask16[15:8];
      ABUSWIDTH'(REG_CTRL):    w_rd_data = {6'b0, r_discard, RX_READY_ALL};
      ABUSWIDTH'(REG_CNT_SEL): w_rd_data = w_sel8;
      ABUSWIDTH'(REG_CNT0):    w_rd_data = w_cnt_live[7:0];
      ABUSWIDTH'(REG_CNT1):    w_rd_data = w_snap[15:8];
      ABUSWIDTH'(REG_CNT2):    w_rd_data = w_snap[23:16];
      ABUSWIDTH'(REG_CNT3):    w_rd_data = w_snap[31:24];
      ABUSWIDTH'(REG_ERR_LO):  w_rd_data = w_err16[7:0];
      ABUSWIDTH'(REG_ERR_HI):  w_rd_data = w_err16[15:8];
      default:                 w_rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RD) r_bus_data <= w_rd_data;
  end

  assign BUS_DATA_OUT = r_bus_data;

endmodule

// File: tb/tb_tpx3_rx_mux.sv
// Scoreboard bench for tpx3_rx_mux: queue-modelled source FIFOs, expected-word queue, negedge monitor.
module tb_tpx3_rx_mux;

  localparam int NUM_CH = 4;
`ifdef TPX3_RX_MUX_WORD_CNT_EN
  localparam logic [7:0] CNT0_EXP = 8'h03;
  localparam logic [7:0] SEL1_EXP = 8'h01;
`else
  localparam logic [7:0] CNT0_EXP = 8'h00;
  localparam logic [7:0] SEL1_EXP = 8'h00;
`endif

  logic              BUS_CLK = 1'b0;
  logic              RST;
  logic [NUM_CH-1:0] CH_EMPTY, CH_READ, CH_READY, CH_DEC_ERR;
  logic [NUM_CH*25-1:0] CH_DATA;
  logic              FIFO_READ, FIFO_EMPTY, RX_READY_ALL;
  logic [31:0]       FIFO_DATA, BUS_ADD;
  logic [7:0]        BUS_DATA_IN, BUS_DATA_OUT;
  logic              BUS_WR, BUS_RD;

  tpx3_rx_mux #(.NUM_CH(NUM_CH), .DATA_IDENTIFIER(7'h15), .ABUSWIDTH(32)) dut (
    .BUS_CLK(BUS_CLK), .RST(RST), .CH_EMPTY(CH_EMPTY), .CH_DATA(CH_DATA), .CH_READ(CH_READ),
    .CH_READY(CH_READY), .CH_DEC_ERR(CH_DEC_ERR), .FIFO_READ(FIFO_READ), .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_DATA(FIFO_DATA), .RX_READY_ALL(RX_READY_ALL), .BUS_ADD(BUS_ADD), .BUS_DATA_IN(BUS_DATA_IN),
    .BUS_DATA_OUT(BUS_DATA_OUT), .BUS_WR(BUS_WR), .BUS_RD(BUS_RD)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  logic [24:0]       src_q [NUM_CH][$];
  logic [31:0]       exp_q [$];
  logic [NUM_CH-1:0] pend = '0;
  int                rd_total [NUM_CH];
  int                n_multi = 0;
  int                m_checks = 0, m_errors = 0;
  int                checks = 0, errors = 0;

  // Expected word: 5-bit identifier 0x15, 2-bit channel, 25-bit payload.
  function automatic logic [31:0] ew(input int ch, input logic [24:0] p);
    return {5'h15, 2'(ch), p};
  endfunction

  initial for (int k = 0; k < NUM_CH; k++) rd_total[k] = 0;

  // Monitor: CH_READ seen here is what the DUT acts on at the next rising edge.
  always @(negedge BUS_CLK) begin
    logic [31:0] w;
    pend = CH_READ;
    for (int k = 0; k < NUM_CH; k++) rd_total[k] += int'(CH_READ[k]);
    if ($countones(CH_READ) > 1) n_multi++;
    if (FIFO_READ && !FIFO_EMPTY) begin
      m_checks++;
      if (exp_q.size() == 0) begin
        m_errors++;
        $display("FAIL scoreboard: got %h, required nothing (queue empty)", FIFO_DATA);
      end else begin
        w = exp_q.pop_front();
        if (FIFO_DATA !== w) begin
          m_errors++;
          $display("FAIL scoreboard: got %h, required %h", FIFO_DATA, w);
        end else $display("word %h ok", FIFO_DATA);
      end
    end
  end

  task automatic refresh();
    for (int k = 0; k < NUM_CH; k++) begin
      CH_EMPTY[k] = (src_q[k].size() == 0);
      CH_DATA[25*k +: 25] = (src_q[k].size() == 0) ? 25'h0 : src_q[k][0];
    end
  endtask

  task automatic tick();
    @(posedge BUS_CLK);
    #1;
    for (int k = 0; k < NUM_CH; k++)
      if (pend[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
    refresh();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end else $display("check %s = %h ok", name, act);
  endtask

  task automatic bus_write(input int a, input logic [7:0] d);
    BUS_ADD = 32'(a); BUS_DATA_IN = d; BUS_WR = 1'b1;
    tick();
    BUS_WR = 1'b0;
  endtask

  task automatic bus_read(input int a, output logic [7:0] d);
    BUS_ADD = 32'(a); BUS_RD = 1'b1;
    tick();
    BUS_RD = 1'b0;
    d = BUS_DATA_OUT;
  endtask

  task automatic rd_check(input string name, input int a, input logic [7:0] req);
    logic [7:0] d;
    bus_read(a, d);
    check(name, 32'(d), 32'(req));
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < budget) begin
      tick();
      n++;
      busy = (exp_q.size() != 0);
      for (int k = 0; k < NUM_CH; k++) if (src_q[k].size() != 0) busy = 1'b1;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  initial begin
    int base, nonempty;
    RST = 1'b1; FIFO_READ = 1'b0; CH_READY = '1; CH_DEC_ERR = '0;
    BUS_ADD = '0; BUS_DATA_IN = '0; BUS_WR = 1'b0; BUS_RD = 1'b0;
    refresh();

    // Reset and register defaults
    tick(); tick();
    check("rst_fifo_empty", 32'(FIFO_EMPTY), 32'd1);
    check("rst_ch_read", 32'(CH_READ), 32'd0);
    RST = 1'b0;
    tick();
    check("rst_fifo_data", FIFO_DATA, 32'h0);
    rd_check("version", 0, 8'h02);
    rd_check("mask_lo_rst", 1, 8'h00);
    rd_check("mask_hi_rst", 2, 8'h00);
    rd_check("ctrl_rst", 3, 8'h01);
    rd_check("unmapped", 15, 8'h00);

    // Single channel with one-cycle latency and two buffered words
    bus_write(1, 8'h04);
    base = rd_total[2];
    src_q[2].push_back(25'h0000ABC); src_q[2].push_back(25'h1FFFFFF);
    exp_q.push_back(32'hAC000ABC); exp_q.push_back(32'hADFFFFFF);
    refresh();
    check("lat_before", 32'(FIFO_EMPTY), 32'd1);
    tick();
    check("lat_after", 32'(FIFO_EMPTY), 32'd0);
    check("head_word", FIFO_DATA, 32'hAC000ABC);
    tick();
    FIFO_READ = 1'b1;
    wait_drain("single_drain", 20);
    check("ch2_reads", 32'(rd_total[2] - base), 32'd2);

    // Fairness after soft reset: rr restarts at channel 0
    bus_write(0, 8'h00);
    rd_check("mask_soft_rst", 1, 8'h00);
    bus_write(1, 8'h0F);
    base = n_multi;
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < NUM_CH; c++) begin
        src_q[c].push_back(25'(c * 25'h100 + i));
        exp_q.push_back(ew(c, 25'(c * 25'h100 + i)));
      end
    refresh();
    wait_drain("fair_drain", 40);
    check("no_multi_read", 32'(n_multi - base), 32'd0);

    // Backpressure: two words fill the buffer, then 1 word/cycle drain
    FIFO_READ = 1'b0;
    base = rd_total[0];
    for (int i = 0; i < 6; i++) begin
      src_q[0].push_back(25'(25'h40 + i));
      exp_q.push_back(ew(0, 25'(25'h40 + i)));
    end
    refresh();
    for (int i = 0; i < 10; i++) tick();
    check("bp_reads", 32'(rd_total[0] - base), 32'd2);
    FIFO_READ = 1'b1;
    nonempty = 0;
    for (int i = 0; i < 6; i++) begin
      nonempty += int'(!FIFO_EMPTY);
      tick();
    end
    check("bp_throughput", 32'(nonempty), 32'd6);
    check("bp_empty_after", 32'(FIFO_EMPTY), 32'd1);

    // Discard mode and counters
    bus_write(0, 8'h00);
    bus_write(1, 8'h01);
    bus_write(3, 8'h02);
    base = rd_total[1];
    for (int i = 0; i < 5; i++) src_q[1].push_back(25'(25'h1000 + i));
    for (int i = 0; i < 3; i++) begin
      src_q[0].push_back(25'(25'h2000 + i));
      exp_q.push_back(ew(0, 25'(25'h2000 + i)));
    end
    refresh();
    wait_drain("discard_drain", 30);
    check("ch1_discards", 32'(rd_total[1] - base), 32'd5);
    rd_check("ctrl_discard", 3, 8'h03);
    CH_READY = 4'b1110;
    #1 check("ready_enabled_low", 32'(RX_READY_ALL), 32'd0);
    rd_check("ctrl_not_ready", 3, 8'h02);
    CH_READY = 4'b1101;
    #1 check("ready_disabled_low", 32'(RX_READY_ALL), 32'd1);
    CH_READY = '1;
    bus_write(4, 8'h00);
    rd_check("cnt0_b0", 5, CNT0_EXP);
    rd_check("cnt0_b1", 6, 8'h00);
    rd_check("cnt0_b2", 7, 8'h00);
    rd_check("cnt0_b3", 8, 8'h00);
    bus_write(4, 8'h01);
    rd_check("cnt_sel", 4, SEL1_EXP);
    rd_check("cnt1_b0", 5, 8'h00);
    rd_check("cnt1_b1", 6, 8'h00);

    // Sticky decoder errors
    CH_DEC_ERR = 4'b1000;
    tick();
    CH_DEC_ERR = '0;
    rd_check("err_set", 9, 8'h08);
    rd_check("err_hi", 10, 8'h00);
    bus_write(9, 8'h08);
    rd_check("err_clr", 9, 8'h00);
    CH_DEC_ERR = 4'b0001;
    bus_write(9, 8'h01);
    CH_DEC_ERR = '0;
    rd_check("err_set_wins", 9, 8'h01);

    // Soft reset drops buffered words but leaves sources alone
    bus_write(3, 8'h00);
    FIFO_READ = 1'b0;
    for (int i = 0; i < 3; i++) src_q[0].push_back(25'(25'h3000 + i));
    refresh();
    for (int i = 0; i < 3; i++) tick();
    check("pre_rst_full", 32'(FIFO_EMPTY), 32'd0);
    bus_write(0, 8'h00);
    check("soft_rst_empty", 32'(FIFO_EMPTY), 32'd1);
    check("soft_rst_data", FIFO_DATA, 32'h0);
    FIFO_READ = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("src_untouched", 32'(src_q[0].size()), 32'd1);
    rd_check("mask_after_soft", 1, 8'h00);
    check("scoreboard_left", 32'(exp_q.size()), 32'd0);

    checks += m_checks;
    errors += m_errors;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
